// File: rtl/qam16_demod.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// qam16_demod
//
// 16-QAM hard-decision demodulator. Signed 8-bit I/Q samples arriving inside
// a start/done framed burst are sliced per axis to a 2-bit Gray code and
// combined into a 4-bit symbol. The decision is I in [3:2] and Q in [1:0].
// A low-confidence flag marks symbols where either component lay close to a
// decision threshold. A saturating counter reports how many symbols the
// current or most recent burst produced.
//
// Parameters
//   AMP     unit constellation amplitude; levels are +-AMP and +-3*AMP (1..42)
//   MARGIN  half-width of the low-confidence band around each threshold
//           (0 .. AMP-1)
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous reset, active low
//   start         opens a burst (only while idle)
//   I_data        in-phase sample, signed
//   Q_data        quadrature sample, signed
//   data_valid_i  I/Q sample valid this cycle
//   done_flag_i   end of burst (only while running)
//   symbol        decided Gray symbol, holds between valid outputs
//   conf_low      low-confidence flag for symbol, holds between valid outputs
//   data_valid_o  symbol/conf_low valid this cycle
//   done_flag_o   one-cycle end-of-burst pulse
//   sym_count     symbols output in the current/last burst, saturating
//   busy          high while a burst is running or flushing
// ---------------------------------------------------------------------------
module qam16_demod #(
  parameter int AMP    = 32,
  parameter int MARGIN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] I_data,
  input  logic signed [7:0] Q_data,
  input  logic              data_valid_i,
  input  logic              done_flag_i,
  output logic [3:0]        symbol,
  output logic              conf_low,
  output logic              data_valid_o,
  output logic              done_flag_o,
  output logic [15:0]       sym_count,
  output logic              busy
);

  // Thresholds are held at 10 bits so that x - t can never overflow, even
  // for -128 against +2*AMP or 127 against -2*AMP.
  localparam logic signed [9:0] THR_LO   = 10'(-2 * AMP);
  localparam logic signed [9:0] THR_MID  = 10'sd0;
  localparam logic signed [9:0] THR_HI   = 10'(2 * AMP);
  localparam logic signed [9:0] MARGIN_S = 10'(MARGIN);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t state;

  // Gray mapping of one axis. A value sitting exactly on a threshold belongs
  // to the region above it, which falls out of using strict less-than.
  function automatic logic [1:0] slice_axis(input logic signed [9:0] x);
    if (x < THR_LO) begin
      return 2'b00;
    end else if (x < THR_MID) begin
      return 2'b01;
    end else if (x < THR_HI) begin
      return 2'b11;
    end else begin
      return 2'b10;
    end
  endfunction

  // True when x is strictly closer than MARGIN to threshold t. With
  // MARGIN = 0 the magnitude can never be below it, so the flag stays low.
  function automatic logic near_threshold(input logic signed [9:0] x,
                                          input logic signed [9:0] t);
    logic signed [9:0] diff;
    logic signed [9:0] mag;
    diff = x - t;
    mag  = diff[9] ? -diff : diff;
    return mag < MARGIN_S;
  endfunction

  logic signed [9:0] i_ext;
  logic signed [9:0] q_ext;
  logic [1:0]        i_dec;
  logic [1:0]        q_dec;
  logic              conf_next;
  logic              accept_sample;
  logic              accept_done;

  // Stage 1 registers
  logic              s1_valid;
  logic              s1_done;
  logic [3:0]        s1_sym;
  logic              s1_conf;

  // Samples and the done marker are only taken while a burst is running;
  // anything presented while idle or flushing is dropped here.
  assign accept_sample = (state == RUN) && data_valid_i;
  assign accept_done   = (state == RUN) && done_flag_i;

  // Sign-extend to 10 bits, then slice both axes and evaluate the
  // confidence band around all three thresholds on both axes.
  always_comb begin
    i_ext     = {{2{I_data[7]}}, I_data};
    q_ext     = {{2{Q_data[7]}}, Q_data};
    i_dec     = slice_axis(i_ext);
    q_dec     = slice_axis(q_ext);
    conf_next = near_threshold(i_ext, THR_LO) |
                near_threshold(i_ext, THR_MID) |
                near_threshold(i_ext, THR_HI) |
                near_threshold(q_ext, THR_LO) |
                near_threshold(q_ext, THR_MID) |
                near_threshold(q_ext, THR_HI);
  end

  // Burst framing. busy is registered alongside the state so it rises the
  // cycle after start is taken. Leaving FLUSH is keyed off done_flag_o,
  // so the FSM is back in IDLE the cycle after the end pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (done_flag_i) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          if (done_flag_o) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: markers always advance; the decision payload only loads when a
  // sample is accepted so it does not toggle on empty cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_done  <= 1'b0;
      s1_sym   <= 4'd0;
      s1_conf  <= 1'b0;
    end else begin
      s1_valid <= accept_sample;
      s1_done  <= accept_done;
      if (accept_sample) begin
        s1_sym  <= {i_dec, q_dec};
        s1_conf <= conf_next;
      end
    end
  end

  // Stage 2: output registers. symbol and conf_low keep the last decision
  // while no new sample is coming out of the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_valid_o <= 1'b0;
      done_flag_o  <= 1'b0;
      symbol       <= 4'd0;
      conf_low     <= 1'b0;
    end else begin
      data_valid_o <= s1_valid;
      done_flag_o  <= s1_done;
      if (s1_valid) begin
        symbol   <= s1_sym;
        conf_low <= s1_conf;
      end
    end
  end

  // Symbol counter: cleared when a new burst opens, otherwise counts every
  // cycle that presents a valid symbol and sticks at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_count <= 16'd0;
    end else if ((state == IDLE) && start) begin
      sym_count <= 16'd0;
    end else if (data_valid_o && (sym_count != 16'hFFFF)) begin
      sym_count <= sym_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_qam16_demod.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_qam16_demod
//
// Self-checking bench for qam16_demod. A behavioural model keeps a queue of
// expected outputs, each tagged with the cycle it must appear in, and derives
// symbols and confidence flags from the slicing rules with plain integer
// arithmetic. Each test task drives its scenario and compares the full output
// vector against the model every cycle, plus a few fixed expectations.
// ---------------------------------------------------------------------------
module tb_qam16_demod;

  localparam int AMP    = 32;
  localparam int MARGIN = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic signed [7:0] I_data;
  logic signed [7:0] Q_data;
  logic              data_valid_i;
  logic              done_flag_i;
  logic [3:0]        symbol;
  logic              conf_low;
  logic              data_valid_o;
  logic              done_flag_o;
  logic [15:0]       sym_count;
  logic              busy;

  always #5 clk = ~clk;

  qam16_demod #(.AMP(AMP), .MARGIN(MARGIN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .I_data       (I_data),
    .Q_data       (Q_data),
    .data_valid_i (data_valid_i),
    .done_flag_i  (done_flag_i),
    .symbol       (symbol),
    .conf_low     (conf_low),
    .data_valid_o (data_valid_o),
    .done_flag_o  (done_flag_o),
    .sym_count    (sym_count),
    .busy         (busy)
  );

  typedef struct {
    int         due;
    logic       vld;
    logic       dne;
    logic [3:0] sym;
    logic       conf;
  } exp_t;

  exp_t       pend[$];
  int         checks = 0;
  int         fails  = 0;
  int         cyc    = 0;
  bit         m_active;
  bit         m_running;
  int         m_cnt;
  logic [3:0] e_sym;
  logic       e_conf;
  logic       e_valid;
  logic       e_done;
  logic       e_busy;
  bit         prev_valid;
  bit         prev_done;

  // Reference slicer: region of x relative to -2A, 0, +2A.
  function automatic logic [1:0] ref_axis(input int x);
    if (x < -2 * AMP) return 2'b00;
    if (x < 0)        return 2'b01;
    if (x < 2 * AMP)  return 2'b11;
    return 2'b10;
  endfunction

  function automatic logic ref_conf(input int i, input int q);
    int xs[2];
    int ts[3];
    int d;
    xs = '{i, q};
    ts = '{-2 * AMP, 0, 2 * AMP};
    foreach (xs[a]) begin
      foreach (ts[b]) begin
        d = xs[a] - ts[b];
        if (d < 0) d = -d;
        if (d < MARGIN) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Mix of uniform values, values hugging thresholds and noisy
  // constellation points.
  function automatic int rand_comp();
    int pick;
    pick = int'($urandom_range(0, 2));
    case (pick)
      0:       return int'($urandom_range(0, 255)) - 128;
      1:       return (int'($urandom_range(0, 2)) - 1) * 2 * AMP
                      + int'($urandom_range(0, 2 * MARGIN)) - MARGIN;
      default: return (2 * int'($urandom_range(0, 3)) - 3) * AMP
                      + int'($urandom_range(0, 6)) - 3;
    endcase
  endfunction

  task automatic model_clear();
    pend.delete();
    m_active   = 0;
    m_running  = 0;
    m_cnt      = 0;
    e_sym      = 4'd0;
    e_conf     = 1'b0;
    e_valid    = 1'b0;
    e_done     = 1'b0;
    e_busy     = 1'b0;
    prev_valid = 0;
    prev_done  = 0;
  endtask

  // Drive one cycle of inputs, advance past the next rising edge and update
  // the model's expectation of what the outputs must show now.
  task automatic step(input logic s, input logic v, input logic d,
                      input int i, input int q);
    exp_t e;
    exp_t h;
    bit   take_start;
    bit   take_v;
    bit   take_d;
    start        = s;
    data_valid_i = v;
    done_flag_i  = d;
    I_data       = 8'(i);
    Q_data       = 8'(q);
    take_start   = !m_active && s;
    take_v       = m_running && v;
    take_d       = m_running && d;
    if (take_v || take_d) begin
      e.due  = cyc + 2;
      e.vld  = take_v;
      e.dne  = take_d;
      e.sym  = take_v ? {ref_axis(i), ref_axis(q)} : 4'd0;
      e.conf = take_v ? ref_conf(i, q) : 1'b0;
      pend.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (prev_valid && m_cnt < 65535) m_cnt++;
    if (prev_done) m_active = 0;
    if (take_start) begin
      m_active  = 1;
      m_running = 1;
      m_cnt     = 0;
    end
    if (take_d) m_running = 0;
    e_valid = 1'b0;
    e_done  = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      h       = pend.pop_front();
      e_valid = h.vld;
      e_done  = h.dne;
      if (h.vld) begin
        e_sym  = h.sym;
        e_conf = h.conf;
      end
    end
    e_busy     = m_active;
    prev_valid = e_valid;
    prev_done  = e_done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 0; data_valid_i = 0; done_flag_i = 0; I_data = 0; Q_data = 0;
    #2;
    checks++;
    if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !== 23'd0) begin
      fails++;
      $display("[TB] FAIL reset_async: outputs=%h expected 0",
               {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count});
    end
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    checks++;
    if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !== 23'd0) begin
      fails++;
      $display("[TB] FAIL reset_held: outputs=%h expected 0",
               {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count});
    end
    rst = 1'b1;
    model_clear();
  endtask

  task automatic test_nominal();
    int         si[4] = '{-96, -32, 32, 96};
    int         sq[4] = '{-96, 32, 96, -32};
    logic [3:0] want[4] = '{4'b0000, 4'b0111, 4'b1110, 4'b1001};
    logic [3:0] got[8];
    logic       gotc[8];
    int         gotcyc[8];
    int         n = 0;
    int         first_cyc = 0;
    int         done_in_cyc;
    int         done_cyc = -1;
    $display("[TB] nominal decode");
    for (int k = 0; k < 11; k++) begin
      if (k == 0)     step(1, 0, 0, 0, 0);
      else if (k < 5) step(0, 1, 0, si[k-1], sq[k-1]);
      else if (k == 5) step(0, 0, 1, 0, 0);
      else            step(0, 0, 0, 0, 0);
      if (k == 1) first_cyc = cyc;
      if (k == 5) done_in_cyc = cyc;
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL nominal cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
      if (data_valid_o === 1'b1 && n < 8) begin
        got[n] = symbol; gotc[n] = conf_low; gotcyc[n] = cyc; n++;
      end
      if (done_flag_o === 1'b1) done_cyc = cyc;
    end
    checks++;
    if (n !== 4) begin
      fails++;
      $display("[TB] FAIL nominal_count: got %0d symbols, expected 4", n);
    end
    for (int k = 0; k < 4 && k < n; k++) begin
      checks++;
      if ({got[k], gotc[k], gotcyc[k]} !== {want[k], 1'b0, first_cyc + 1 + k}) begin
        fails++;
        $display("[TB] FAIL nominal_sym%0d: got sym=%b conf=%b cyc=%0d, expected sym=%b conf=0 cyc=%0d",
                 k, got[k], gotc[k], gotcyc[k], want[k], first_cyc + 1 + k);
      end
    end
    checks++;
    if (done_cyc !== done_in_cyc + 1) begin
      fails++;
      $display("[TB] FAIL nominal_done: done_flag_o at cycle %0d, expected %0d",
               done_cyc, done_in_cyc + 1);
    end
    checks++;
    if (sym_count !== 16'd4) begin
      fails++;
      $display("[TB] FAIL nominal_symcount: got %0d expected 4", sym_count);
    end
  endtask

  task automatic test_boundary();
    int         si[4] = '{0, -128, 61, 60};
    int         sq[4] = '{-64, 127, 3, 4};
    logic [4:0] want[4] = '{5'b1101_1, 5'b0010_0, 5'b1111_1, 5'b1111_0};
    int         n = 0;
    $display("[TB] boundary and extreme values");
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      step(1, 0, 0, 0, 0);
      else if (k < 4)  step(0, 1, 0, si[k-1], sq[k-1]);
      else if (k == 4) step(0, 1, 1, si[3], sq[3]);
      else             step(0, 0, 0, 0, 0);
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL boundary cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
      if (data_valid_o === 1'b1 && n < 4) begin
        checks++;
        if ({symbol, conf_low} !== want[n]) begin
          fails++;
          $display("[TB] FAIL boundary_sym%0d (%0d,%0d): got sym=%b conf=%b, expected %b/%b",
                   n, si[n], sq[n], symbol, conf_low, want[n][4:1], want[n][0]);
        end
        n++;
      end
    end
    checks++;
    if (n !== 4) begin
      fails++;
      $display("[TB] FAIL boundary_count: got %0d symbols, expected 4", n);
    end
  endtask

  task automatic test_framing();
    int n_coinc = 0;
    $display("[TB] framing");
    for (int k = 0; k < 16; k++) begin
      if (k < 3)        step(0, 1, 0, rand_comp(), rand_comp());
      else if (k == 3)  step(0, 1, 1, rand_comp(), rand_comp());
      else if (k == 4)  step(1, 0, 0, 0, 0);
      else if (k < 8)   step(0, 1, 0, rand_comp(), rand_comp());
      else if (k == 8)  step(1, 1, 0, rand_comp(), rand_comp());
      else if (k == 9)  step(0, 1, 1, rand_comp(), rand_comp());
      else              step(0, 1, 0, rand_comp(), rand_comp());
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL framing cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
      if (done_flag_o === 1'b1 && data_valid_o === 1'b1) n_coinc++;
    end
    checks++;
    if (n_coinc !== 1 || sym_count !== 16'd5) begin
      fails++;
      $display("[TB] FAIL framing_last: coincident done/valid=%0d count=%0d, expected 1 and 5",
               n_coinc, sym_count);
    end
  endtask

  task automatic test_gapped();
    int vcyc[$];
    $display("[TB] gapped input");
    for (int k = 0; k < 16; k++) begin
      if (k == 0)                       step(1, 0, 0, 0, 0);
      else if (k <= 9 && (k % 3) == 1)  step(0, 1, 0, rand_comp(), rand_comp());
      else if (k == 10)                 step(0, 0, 1, 0, 0);
      else                              step(0, 0, 0, 0, 0);
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL gapped cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
      if (data_valid_o === 1'b1) vcyc.push_back(cyc);
    end
    checks++;
    if (vcyc.size() !== 3 || vcyc[1] - vcyc[0] !== 3 || vcyc[2] - vcyc[1] !== 3 ||
        sym_count !== 16'd3) begin
      fails++;
      $display("[TB] FAIL gapped_spacing: %0d outputs, count=%0d, expected 3 outputs 3 cycles apart, count 3",
               vcyc.size(), sym_count);
    end
  endtask

  task automatic test_reset_mid();
    $display("[TB] reset mid-burst");
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, rand_comp(), rand_comp());
    step(0, 1, 0, rand_comp(), rand_comp());
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
    start = 0; data_valid_i = 0; done_flag_i = 0;
    #2;
    checks++;
    if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !== 23'd0) begin
      fails++;
      $display("[TB] FAIL reset_mid_async: outputs=%h expected 0",
               {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count});
    end
    @(posedge clk); #1; cyc++;
    rst = 1'b1;
    model_clear();
    for (int k = 0; k < 18; k++) begin
      if (k < 4)        step(0, 0, 0, 0, 0);
      else if (k == 4)  step(1, 0, 0, 0, 0);
      else if (k < 10)  step(0, 1, 0, rand_comp(), rand_comp());
      else if (k == 10) step(0, 0, 1, 0, 0);
      else              step(0, 0, 0, 0, 0);
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL reset_mid cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
    end
  endtask

  task automatic test_back_to_back();
    int len;
    $display("[TB] randomized back-to-back bursts");
    for (int b = 0; b < 6; b++) begin
      for (int w = 0; w < 6 && !m_running; w++) begin
        step(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_comp(), rand_comp());
        checks++;
        if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
            {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
          fails++;
          $display("[TB] FAIL b2b_start cycle %0d: outputs=%h expected %h", cyc,
                   {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                   {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
        end
      end
      len = int'($urandom_range(1, 20));
      for (int k = 0; k <= len; k++) begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), k == len,
             rand_comp(), rand_comp());
        checks++;
        if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
            {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
          fails++;
          $display("[TB] FAIL b2b_data cycle %0d: outputs=%h expected %h", cyc,
                   {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                   {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, 0);
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL b2b_drain cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
    end
  endtask

  task automatic test_saturation();
    $display("[TB] counter saturation");
    for (int k = 0; k < 65548; k++) begin
      if (k == 0)          step(1, 0, 0, 0, 0);
      else if (k <= 65540) step(0, 1, k == 65540, rand_comp(), rand_comp());
      else                 step(0, 0, 0, 0, 0);
      checks++;
      if ({data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count} !==
          {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)}) begin
        fails++;
        $display("[TB] FAIL saturation cycle %0d: outputs=%h expected %h", cyc,
                 {data_valid_o, done_flag_o, busy, symbol, conf_low, sym_count},
                 {e_valid, e_done, e_busy, e_sym, e_conf, 16'(m_cnt)});
      end
    end
    checks++;
    if (sym_count !== 16'hFFFF) begin
      fails++;
      $display("[TB] FAIL saturation_hold: got %h expected ffff", sym_count);
    end
    step(1, 0, 0, 0, 0);
    checks++;
    if ({busy, sym_count} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("[TB] FAIL saturation_clear: busy=%b count=%h, expected busy=1 count=0000",
               busy, sym_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_clear();
    test_reset();
    test_nominal();
    test_boundary();
    test_framing();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
